fc_mac_sequencer: RTL and testbench
===================================

// Module: fc_mac_sequencer
// PURPOSE
//  Sequences one shared MAC_UNIT to compute the fully-connected output layer y = W*x + b after the BiLSTM.
//  - Walks weight, input and bias memories row by row.
//  - Drives the MAC operand and accumulator-feedback ports.
//  - Rescales and saturates each row result.
//  - Emits each result over a valid/ready stream.
//  Sits between the BiLSTM hidden-state buffer / weight ROMs and the localization output stage.
// PARAMETERS
//  DATA_WIDTH  16  width of x, W, b and out_data; signed fixed point with FRAC_BITS fraction bits
//  ACC_WIDTH   32  MAC accumulator width; must be >= 2*DATA_WIDTH
//  IN_LEN      64  input vector length (MAC beats per row), >= 1
//  OUT_LEN     3   number of output rows, >= 1
//  FRAC_BITS   8   fraction bits of the data format
// PORTS
//  clk         in   1                         clock
//  rst         in   1                         asynchronous, active-high reset
//  start       in   1                         start a full layer pass; accepted only when busy=0
//  busy        out  1                         high from the cycle after start is accepted until done
//  done        out  1                         one-cycle pulse after the last row handshake
//  w_addr      out  $clog2(IN_LEN*OUT_LEN)    weight address, row*IN_LEN+k
//  w_data      in   DATA_WIDTH                weight data; synchronous read, 1-cycle latency
//  x_addr      out  $clog2(IN_LEN)            input-vector address, k
//  x_data      in   DATA_WIDTH                input data; 1-cycle latency
//  b_addr      out  $clog2(OUT_LEN)           bias address = row
//  b_data      in   DATA_WIDTH                bias data; 1-cycle latency
//  mac_en      out  1                         MAC enable
//  mac_a       out  DATA_WIDTH                MAC operand a (= x_data)
//  mac_b       out  DATA_WIDTH                MAC operand b (= w_data)
//  mac_acc_in  out  ACC_WIDTH                 MAC accumulator input
//  mac_acc_out in   ACC_WIDTH                 registered MAC result
//  out_valid   out  1                         result valid
//  out_ready   in   1                         downstream ready
//  out_data    out  DATA_WIDTH                saturated row result
//  out_idx     out  $clog2(OUT_LEN)           row index of out_data
// BEHAVIOUR
//  Reset: FSM=IDLE; row=0, k=0.
//   - Outputs: busy, done, mac_en, out_valid = 0; all addresses, out_data, out_idx = 0.
//   - Reset mid-pass aborts immediately; no partial result or done is emitted.
//  FSM states: IDLE -> PRIME -> MAC -> WAIT -> OUT -> (PRIME | IDLE).
//  IDLE:
//   - On start: row=0, go to PRIME. busy rises next cycle.
//   - start while not IDLE is ignored.
//  PRIME (1 cycle): drive w_addr=row*IN_LEN, x_addr=0, b_addr=row; k=0; go to MAC.
//  MAC (IN_LEN cycles, beat k=0..IN_LEN-1):
//   - mac_en=1; mac_a=x_data, mac_b=w_data (data for beat k).
//   - Concurrently issue addresses for k+1; addresses hold on the last beat.
//   - mac_acc_in:
//     - k=0: sign_extend(b_data) <<< FRAC_BITS (bias aligned to product scale).
//     - k>0: mac_acc_out (back-to-back feedback; the MAC register holds beat k-1).
//  WAIT (1 cycle): mac_en=0 so the final beat lands in mac_acc_out.
//  OUT:
//   - Register out_data = sat(mac_acc_out >>> FRAC_BITS) to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
//   - out_idx=row; out_valid=1.
//   - out_data and out_idx are stable while out_valid && !out_ready; mac_en=0 while stalled.
//   - On out_valid && out_ready:
//     - row<OUT_LEN-1: row++, go to PRIME.
//     - Else: done=1 for that next cycle, busy=0, go to IDLE.
//  Latency:
//   - Start accepted in cycle 0: PRIME cycle 1, MAC cycles 2..IN_LEN+1, WAIT IN_LEN+2, first out_valid IN_LEN+3.
//   - Each row costs IN_LEN+3 cycles with out_ready held high.
//  mac_en is never asserted outside MAC; MAC reset is the shared rst.
//  Accumulator overflow wraps (MAC behaviour); only the final rescale saturates.
//  IN_LEN=1: MAC lasts exactly one beat, with the bias path only.
//  start coinciding with done (state IDLE that cycle) is accepted.
// TESTING
//  Use IN_LEN=4, OUT_LEN=2, FRAC_BITS=8.
//  1. x=256 x4, W row0=128 x4, b0=64, out_ready=1:
//     -> out_idx=0, out_data=576 (2.25), first out_valid exactly 7 cycles after start.
//  2. Row1 W=-256 x4, b1=0 -> out_data=-1024; done pulses 1 cycle after the row-1 handshake; busy falls with it.
//  3. Saturation:
//     - x=W=32512 x4 -> out_data=32767.
//     - x=32512, W=-32512 -> out_data=-32768.
//  4. Backpressure: out_ready low 5 cycles in OUT
//     -> out_data/out_idx stable, mac_en=0, no address change, row advances only on the handshake.
//  5. Pulse start during MAC -> ignored, result unchanged.
//     Assert rst during MAC of row 1 -> all outputs 0 next edge, no done; a new start reruns from row 0 correctly.
//  6. IN_LEN=1 build: x=256, W=256, b=256 -> out_data=512, out_valid 4 cycles after start.

Source files
------------

// File: rtl/fc_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fc_mac_sequencer
//  Purpose  : Drives one shared MAC through y = W*x + b, one output row at a
//             time, then rescales, saturates and streams each row result.
//  Revision : 1.0  initial release
// ============================================================================
module fc_mac_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int IN_LEN     = 64,
    parameter int OUT_LEN    = 3,
    parameter int FRAC_BITS  = 8,
    localparam int c_wa_w    = (IN_LEN * OUT_LEN > 1) ? $clog2(IN_LEN * OUT_LEN) : 1,
    localparam int c_xa_w    = (IN_LEN > 1) ? $clog2(IN_LEN) : 1,
    localparam int c_row_w   = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [c_wa_w-1:0]     o_w_addr,
    input  logic [DATA_WIDTH-1:0] i_w_data,
    output logic [c_xa_w-1:0]     o_x_addr,
    input  logic [DATA_WIDTH-1:0] i_x_data,
    output logic [c_row_w-1:0]    o_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_data,
    output logic                  o_mac_en,
    output logic [DATA_WIDTH-1:0] o_mac_a,
    output logic [DATA_WIDTH-1:0] o_mac_b,
    output logic [ACC_WIDTH-1:0]  o_mac_acc_in,
    input  logic [ACC_WIDTH-1:0]  i_mac_acc_out,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic [c_row_w-1:0]    o_out_idx
);

    localparam logic [c_xa_w-1:0]  c_k_last   = c_xa_w'(IN_LEN - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(OUT_LEN - 1);
    localparam logic signed [ACC_WIDTH-1:0] c_sat_max =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_sat_min =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_MAC   = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_mac_en;
    logic                    r_out_valid;
    logic [c_wa_w-1:0]       r_w_addr;
    logic [c_xa_w-1:0]       r_x_addr;
    logic [c_xa_w-1:0]       r_k;
    logic [c_row_w-1:0]      r_row;
    logic [c_row_w-1:0]      r_out_idx;
    logic [DATA_WIDTH-1:0]   r_out_data;

    logic signed [ACC_WIDTH-1:0] w_bias_acc;
    logic signed [ACC_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0]       w_sat;
    logic                        w_addr_last;

    // Bias enters the accumulator pre-scaled so it lines up with x*w products.
    assign w_bias_acc  = {{(ACC_WIDTH-DATA_WIDTH){i_b_data[DATA_WIDTH-1]}}, i_b_data} <<< FRAC_BITS;
    assign w_shifted   = $signed(i_mac_acc_out) >>> FRAC_BITS;
    assign w_addr_last = (r_x_addr == c_k_last);

    always_comb begin
        w_sat = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > c_sat_max) begin
            w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (w_shifted < c_sat_min) begin
            w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    assign o_mac_a      = i_x_data;
    assign o_mac_b      = i_w_data;
    assign o_mac_acc_in = (r_k == '0) ? w_bias_acc : i_mac_acc_out;

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_mac_en    = r_mac_en;
    assign o_out_valid = r_out_valid;
    assign o_w_addr    = r_w_addr;
    assign o_x_addr    = r_x_addr;
    assign o_b_addr    = r_row;
    assign o_out_data  = r_out_data;
    assign o_out_idx   = r_out_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mac_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_w_addr    <= '0;
            r_x_addr    <= '0;
            r_k         <= '0;
            r_row       <= '0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done   <= 1'b0;
                    r_mac_en <= 1'b0;
                    if (i_start) begin
                        r_state  <= S_PRIME;
                        r_busy   <= 1'b1;
                        r_row    <= '0;
                        r_w_addr <= '0;
                        r_x_addr <= '0;
                    end
                end
                S_PRIME: begin
                    r_k      <= '0;
                    r_mac_en <= 1'b1;
                    r_state  <= S_MAC;
                    if (!w_addr_last) begin
                        r_x_addr <= r_x_addr + 1'b1;
                        r_w_addr <= r_w_addr + 1'b1;
                    end
                end
                S_MAC: begin
                    // Addresses run one beat ahead of the data and park on the last element.
                    if (!w_addr_last) begin
                        r_x_addr <= r_x_addr + 1'b1;
                        r_w_addr <= r_w_addr + 1'b1;
                    end
                    if (r_k == c_k_last) begin
                        r_mac_en <= 1'b0;
                        r_state  <= S_WAIT;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_WAIT: begin
                    r_out_data  <= w_sat;
                    r_out_idx   <= r_row;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_row != c_row_last) begin
                            // Weight address sits on the row's last element, so +1 is the next row base.
                            r_row    <= r_row + 1'b1;
                            r_w_addr <= r_w_addr + 1'b1;
                            r_x_addr <= '0;
                            r_state  <= S_PRIME;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fc_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fc_mac_sequencer
//  Purpose  : Directed bench for fc_mac_sequencer with behavioural MACs and
//             synchronous-read memories (IN_LEN=4/OUT_LEN=2 and IN_LEN=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fc_mac_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- 4x2 instance (wide accumulator so saturation is reachable)
    logic        start4 = 1'b0;
    logic        ready4 = 1'b1;
    logic        busy4, done4, mac_en4, out_valid4;
    logic [2:0]  w_addr4;
    logic [1:0]  x_addr4;
    logic [0:0]  b_addr4, out_idx4;
    logic [15:0] w_d4, x_d4, b_d4, mac_a4, mac_b4, out_data4;
    logic [39:0] acc_in4, acc_out4;
    logic signed [39:0] prod4;
    logic [15:0] wm [8];
    logic [15:0] xm [4];
    logic [15:0] bm [2];

    fc_mac_sequencer #(
        .DATA_WIDTH(16), .ACC_WIDTH(40), .IN_LEN(4), .OUT_LEN(2), .FRAC_BITS(8)
    ) dut4 (
        .clk(clk), .rst(rst), .i_start(start4), .o_busy(busy4), .o_done(done4),
        .o_w_addr(w_addr4), .i_w_data(w_d4), .o_x_addr(x_addr4), .i_x_data(x_d4),
        .o_b_addr(b_addr4), .i_b_data(b_d4), .o_mac_en(mac_en4), .o_mac_a(mac_a4),
        .o_mac_b(mac_b4), .o_mac_acc_in(acc_in4), .i_mac_acc_out(acc_out4),
        .o_out_valid(out_valid4), .i_out_ready(ready4), .o_out_data(out_data4),
        .o_out_idx(out_idx4)
    );

    always @(posedge clk) begin
        w_d4 <= wm[w_addr4];
        x_d4 <= xm[x_addr4];
        b_d4 <= bm[b_addr4];
    end

    assign prod4 = $signed(mac_a4) * $signed(mac_b4);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          acc_out4 <= '0;
        else if (mac_en4) acc_out4 <= acc_in4 + prod4;
    end

    // ---------------- IN_LEN=1, OUT_LEN=1 instance
    logic        start1 = 1'b0;
    logic        ready1 = 1'b1;
    logic        busy1, done1, mac_en1, out_valid1;
    logic [0:0]  w_addr1, x_addr1, b_addr1, out_idx1;
    logic [15:0] w_d1, x_d1, b_d1, mac_a1, mac_b1, out_data1;
    logic [31:0] acc_in1, acc_out1;
    logic signed [31:0] prod1;

    fc_mac_sequencer #(
        .DATA_WIDTH(16), .ACC_WIDTH(32), .IN_LEN(1), .OUT_LEN(1), .FRAC_BITS(8)
    ) dut1 (
        .clk(clk), .rst(rst), .i_start(start1), .o_busy(busy1), .o_done(done1),
        .o_w_addr(w_addr1), .i_w_data(w_d1), .o_x_addr(x_addr1), .i_x_data(x_d1),
        .o_b_addr(b_addr1), .i_b_data(b_d1), .o_mac_en(mac_en1), .o_mac_a(mac_a1),
        .o_mac_b(mac_b1), .o_mac_acc_in(acc_in1), .i_mac_acc_out(acc_out1),
        .o_out_valid(out_valid1), .i_out_ready(ready1), .o_out_data(out_data1),
        .o_out_idx(out_idx1)
    );

    always @(posedge clk) begin
        w_d1 <= 16'sd256;
        x_d1 <= 16'sd256;
        b_d1 <= 16'sd256;
    end

    assign prod1 = $signed(mac_a1) * $signed(mac_b1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          acc_out1 <= '0;
        else if (mac_en1) acc_out1 <= acc_in1 + prod1;
    end

    // ---------------- helpers
    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load4(input logic [15:0] xv, input logic [15:0] w0,
                         input logic [15:0] w1, input logic [15:0] b0,
                         input logic [15:0] b1);
        for (int i = 0; i < 4; i++) begin
            xm[i]     = xv;
            wm[i]     = w0;
            wm[i + 4] = w1;
        end
        bm[0] = b0;
        bm[1] = b1;
    endtask

    task automatic start_pass4(input string tag);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check({tag, "_busy_rise"}, busy4, 1);
    endtask

    // Counts negedges until out_valid, plus cycles with mac_en seen on the way.
    task automatic row4(input string tag, input int exp_n, input int exp_en,
                        input logic signed [63:0] exp_d, input int exp_i);
        int n  = 0;
        int en = 0;
        do begin
            @(negedge clk);
            n++;
            if (mac_en4) en++;
        end while (!out_valid4 && n < 40);
        check({tag, "_valid"},   out_valid4, 1);
        check({tag, "_latency"}, n, exp_n);
        if (exp_en >= 0) check({tag, "_mac_beats"}, en, exp_en);
        check({tag, "_data"},    $signed(out_data4), exp_d);
        check({tag, "_idx"},     out_idx4, exp_i);
    endtask

    task automatic finish4(input string tag);
        @(negedge clk);
        check({tag, "_done"},      done4, 1);
        check({tag, "_busy_fall"}, busy4, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done4, 0);
    endtask

    initial begin
        int n1;
        int en1;
        int dones;

        load4(16'sd256, 16'sd128, -16'sd256, 16'sd64, 16'sd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",     busy4, 0);
        check("rst_done",     done4, 0);
        check("rst_mac_en",   mac_en4, 0);
        check("rst_valid",    out_valid4, 0);
        check("rst_w_addr",   w_addr4, 0);
        check("rst_out_data", out_data4, 0);
        check("rst_out_idx",  out_idx4, 0);

        // Rows: 4*(256*128)+64*256 = 147456 -> 576 ; 4*(256*-256) -> -1024
        start_pass4("p1");
        row4("p1_row0", 6, 4, 576, 0);
        row4("p1_row1", 7, 4, -1024, 1);
        finish4("p1");

        load4(16'sd32512, 16'sd32512, -16'sd32512, 16'sd0, 16'sd0);
        start_pass4("sat");
        row4("sat_pos", 6, 4, 32767, 0);
        row4("sat_neg", 7, 4, -32768, 1);
        finish4("sat");

        // Backpressure: ready low for five cycles in OUT.
        load4(16'sd256, 16'sd128, -16'sd256, 16'sd64, 16'sd0);
        ready4 = 1'b0;
        start_pass4("bp");
        row4("bp_row0", 6, 4, 576, 0);
        check("bp_w_addr_hold", w_addr4, 3);
        check("bp_x_addr_hold", x_addr4, 3);
        check("bp_b_addr_hold", b_addr4, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_stall_valid",  out_valid4, 1);
            check("bp_stall_data",   $signed(out_data4), 576);
            check("bp_stall_idx",    out_idx4, 0);
            check("bp_stall_mac_en", mac_en4, 0);
            check("bp_stall_w_addr", w_addr4, 3);
            check("bp_stall_x_addr", x_addr4, 3);
        end
        ready4 = 1'b1;
        @(negedge clk);
        check("bp_hs_valid",  out_valid4, 0);
        check("bp_hs_w_addr", w_addr4, 4);
        check("bp_hs_x_addr", x_addr4, 0);
        check("bp_hs_b_addr", b_addr4, 1);
        check("bp_hs_busy",   busy4, 1);
        row4("bp_row1", 6, 4, -1024, 1);
        finish4("bp");

        // start pulsed during MAC must be ignored.
        start_pass4("ign");
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        row4("ign_row0", 4, 2, 576, 0);
        repeat (3) @(negedge clk);
        check("abort_in_mac", mac_en4, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",     busy4, 0);
        check("abort_mac_en",   mac_en4, 0);
        check("abort_valid",    out_valid4, 0);
        check("abort_done",     done4, 0);
        check("abort_w_addr",   w_addr4, 0);
        check("abort_b_addr",   b_addr4, 0);
        check("abort_out_data", out_data4, 0);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done4 || busy4 || out_valid4) dones++;
        end
        check("abort_quiet", dones, 0);
        start_pass4("rerun");
        row4("rerun_row0", 6, 4, 576, 0);
        row4("rerun_row1", 7, 4, -1024, 1);
        finish4("rerun");

        // IN_LEN=1: 256*256 + (256<<8) = 131072 -> 512, valid 4 cycles after start.
        start1 = 1'b1;
        n1  = 0;
        en1 = 0;
        do begin
            @(negedge clk);
            start1 = 1'b0;
            n1++;
            if (mac_en1) en1++;
        end while (!out_valid1 && n1 < 40);
        check("l1_valid",     out_valid1, 1);
        check("l1_latency",   n1, 4);
        check("l1_mac_beats", en1, 1);
        check("l1_data",      $signed(out_data1), 512);
        check("l1_idx",       out_idx1, 0);
        @(negedge clk);
        check("l1_done", done1, 1);
        check("l1_busy", busy1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
